// File: rtl/nn_mm_arbiter_pkg.sv
// Shared definitions for the NeuralNetwork memory-mapped port arbiter.
package nn_mm_arbiter_pkg;

    localparam int MM_DEPTH = 17;
    localparam int MM_SIZE  = 16;

    typedef struct packed {
        logic                write;
        logic                lock;
        logic [MM_DEPTH-1:0] addr;
        logic [MM_SIZE-1:0]  wdata;
    } mm_req_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_lock_e;

    // Lock FSM register, kept as one struct so the whole state is visible as a single signal.
    typedef struct packed {
        arb_lock_e state;
        logic      owner;
    } lock_state_t;

endpackage

// File: rtl/nn_mm_arbiter_rr.sv
// Two-way round-robin grant with a pointer register and a lock override.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       busy_i,
    input  logic       lock_i,
    input  logic       owner_i,
    input  logic       release_i,
    output logic [1:0] grant_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (!busy_i) begin
            if (lock_i) begin
                grant_o[owner_i] = valid_i[owner_i];
            end else if (valid_i == 2'b11) begin
                grant_o[ptr_q] = 1'b1;
            end else begin
                grant_o = valid_i;
            end
        end
    end

    // Pointer favours the requester that was not just served; a timed-out lock hands over too.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_o[0]) begin
            ptr_d = 1'b1;
        end else if (grant_o[1]) begin
            ptr_d = 1'b0;
        end else if (release_i) begin
            ptr_d = ~owner_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/nn_mm_arbiter.sv
// Shares the NeuralNetwork memory-mapped port between a host bridge (0) and a loader (1).
// Handshake: a beat on requester g transfers in the cycle where req_valid[g] && req_ready[g].
module nn_mm_arbiter
    import nn_mm_arbiter_pkg::*;
#(
    parameter int ADDR_W       = MM_DEPTH,
    parameter int DATA_W       = MM_SIZE,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [1:0]          req_lock,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    input  logic                nn_busy,
    output logic                nn_write_enable,
    output logic [ADDR_W-1:0]   nn_write_addr,
    output logic [DATA_W-1:0]   nn_write_data,
    output logic [ADDR_W-1:0]   nn_read_addr,
    input  logic [DATA_W-1:0]   nn_read_data
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    lock_state_t lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_rel;

    logic [1:0]        grant;
    logic              accept;
    logic              gidx;
    logic              sel_write;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              wr_en_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [1:0]        rd_pend_q;
    logic [1:0]        rsp_valid_q;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst_n     (reset),
        .valid_i   (req_valid),
        .busy_i    (nn_busy),
        .lock_i    (lock_q.state == LOCKED),
        .owner_i   (lock_q.owner),
        .release_i (timeout_rel),
        .grant_o   (grant)
    );

    assign accept    = |grant;
    assign gidx      = grant[1];
    assign sel_write = req_write[gidx];
    assign sel_lock  = req_lock[gidx];
    assign sel_addr  = gidx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign sel_wdata = gidx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    // Ready is combinational, so force it low while reset is asserted.
    assign req_ready = grant & {2{reset}};

    always_comb begin
        lock_d      = lock_q;
        cnt_d       = cnt_q;
        timeout_rel = 1'b0;
        if (accept) begin
            cnt_d = '0;
            if (sel_lock) begin
                lock_d.state = LOCKED;
                lock_d.owner = gidx;
            end else begin
                lock_d.state = UNLOCKED;
            end
        end else if (lock_q.state == LOCKED) begin
            // Idle cycles while locked count toward release, busy cycles included.
            if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                lock_d.state = UNLOCKED;
                cnt_d        = '0;
                timeout_rel  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= '{state: UNLOCKED, owner: 1'b0};
            cnt_q  <= '0;
        end else begin
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q     <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            rd_pend_q   <= 2'b00;
            rsp_valid_q <= 2'b00;
        end else begin
            wr_en_q <= accept && sel_write;
            if (accept && sel_write) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (accept && !sel_write) begin
                raddr_q <= sel_addr;
            end
            // Read data arrives one cycle after the address, so the tag trails by two stages.
            rd_pend_q   <= (accept && !sel_write) ? grant : 2'b00;
            rsp_valid_q <= rd_pend_q;
        end
    end

    assign nn_write_enable = wr_en_q;
    assign nn_write_addr   = waddr_q;
    assign nn_write_data   = wdata_q;
    assign nn_read_addr    = raddr_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = (|rsp_valid_q) ? nn_read_data : '0;

endmodule

// File: tb/tb_nn_mm_arbiter.sv
// Directed bench for nn_mm_arbiter with write/read scoreboards and a small memory model.
module tb_nn_mm_arbiter;
    import nn_mm_arbiter_pkg::*;

    localparam int ADDR_W       = MM_DEPTH;
    localparam int DATA_W       = MM_SIZE;
    localparam int LOCK_TIMEOUT = 16;
    localparam int WE_W         = 16 + ADDR_W + DATA_W;
    localparam int RE_W         = 16 + 1 + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]          req_valid, req_write, req_lock;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready, rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                nn_busy;
    logic                nn_write_enable;
    logic [ADDR_W-1:0]   nn_write_addr, nn_read_addr;
    logic [DATA_W-1:0]   nn_write_data, nn_read_data;

    nn_mm_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_lock        (req_lock),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .nn_busy         (nn_busy),
        .nn_write_enable (nn_write_enable),
        .nn_write_addr   (nn_write_addr),
        .nn_write_data   (nn_write_data),
        .nn_read_addr    (nn_read_addr),
        .nn_read_data    (nn_read_data)
    );

    // Network memory model: read data appears one cycle after the address.
    function automatic logic [DATA_W-1:0] mm_model(logic [ADDR_W-1:0] a);
        return DATA_W'(16'h00C8 + a[15:0] * 16'h0011);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) nn_read_data <= '0;
        else        nn_read_data <= mm_model(nn_read_addr);
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_ready"},   64'(req_ready), 0);
        chk({tag, "_rspv"},    64'(rsp_valid), 0);
        chk({tag, "_rspd"},    64'(rsp_data), 0);
        chk({tag, "_we"},      64'(nn_write_enable), 0);
        chk({tag, "_waddr"},   64'(nn_write_addr), 0);
        chk({tag, "_wdata"},   64'(nn_write_data), 0);
        chk({tag, "_raddr"},   64'(nn_read_addr), 0);
    endtask

    // ---------------- scoreboard ----------------
    logic [WE_W-1:0] wr_exp_q[$];
    logic [RE_W-1:0] rd_exp_q[$];
    logic [WE_W-1:0] we;
    logic [RE_W-1:0] re;

    always @(negedge clk) begin
        chk("ready_onehot", 64'($countones(req_ready) > 1), 0);
        chk("rsp_onehot",   64'($countones(rsp_valid) > 1), 0);
        if (nn_write_enable) begin
            if (wr_exp_q.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                we = wr_exp_q.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(we[WE_W-1 -: 16]));
                chk("wr_addr",  64'(nn_write_addr), 64'(we[ADDR_W+DATA_W-1:DATA_W]));
                chk("wr_data",  64'(nn_write_data), 64'(we[DATA_W-1:0]));
            end
        end else if (wr_exp_q.size() > 0 && int'(wr_exp_q[0][WE_W-1 -: 16]) <= cyc) begin
            we = wr_exp_q.pop_front();
            chk("wr_missing", 64'(nn_write_enable), 1);
        end
        if (rsp_valid != 2'b00) begin
            if (rd_exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 0);
            end else begin
                re = rd_exp_q.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(re[RE_W-1 -: 16]));
                chk("rsp_valid", 64'(rsp_valid), 64'(2'b01 << re[DATA_W]));
                chk("rsp_data",  64'(rsp_data), 64'(re[DATA_W-1:0]));
            end
        end else if (rd_exp_q.size() > 0 && int'(rd_exp_q[0][RE_W-1 -: 16]) <= cyc) begin
            re = rd_exp_q.pop_front();
            chk("rsp_missing", 64'(rsp_valid), 64'(2'b01 << re[DATA_W]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(int idx, logic v, logic w, logic l,
                           logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        req_valid[idx] = v;
        req_write[idx] = w;
        req_lock[idx]  = l;
        if (idx == 0) begin
            req_addr[ADDR_W-1:0]  = a;
            req_wdata[DATA_W-1:0] = d;
        end else begin
            req_addr[2*ADDR_W-1:ADDR_W]  = a;
            req_wdata[2*DATA_W-1:DATA_W] = d;
        end
    endtask

    task automatic idle();
        req_valid = 2'b00;
        req_lock  = 2'b00;
    endtask

    // Called at posedge+1; checks the expected grant mid-cycle and records accepted beats.
    task automatic step(logic [1:0] exp_rdy);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < 2; i++) begin
            if (exp_rdy[i]) begin
                a = (i == 1) ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
                d = (i == 1) ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                if (req_write[i]) wr_exp_q.push_back({16'(cyc + 1), a, d});
                else              rd_exp_q.push_back({16'(cyc + 2), 1'(i), mm_model(a)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b0;
        nn_busy   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset with a request already pending, then a single write.
        set_req(0, 1, 1, 0, 'h4002, 16'd4096);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
        step(2'b01);

        idle();
        set_req(1, 1, 1, 0, 'h4005, 16'd7);
        step(2'b10);

        // Contention: grants alternate.
        for (int k = 0; k < 2; k++) begin
            set_req(0, 1, 1, 0, 'h4003, DATA_W'(1024 + k));
            set_req(1, 1, 1, 0, 'h4004, DATA_W'(512 + k));
            step(2'b01);
            step(2'b10);
        end

        // Read path.
        idle();
        set_req(1, 1, 0, 0, 'h0, '0);
        step(2'b10);
        idle();
        step(2'b00);
        set_req(0, 1, 0, 0, 'h1, '0);
        set_req(1, 1, 0, 0, 'h2, '0);
        step(2'b01);
        step(2'b10);
        idle();
        repeat (2) step(2'b00);

        // Busy stall: write accepted just before busy still issues.
        set_req(0, 1, 1, 0, 'h4010, 16'hAAAA);
        step(2'b01);
        nn_busy = 1'b1;
        set_req(0, 1, 1, 0, 'h4011, 16'h1111);
        set_req(1, 1, 1, 0, 'h4012, 16'h2222);
        repeat (5) step(2'b00);
        nn_busy = 1'b0;
        step(2'b10);
        idle();

        // Lock burst from requester 1 while requester 0 waits.
        set_req(0, 1, 1, 0, 'h4013, 16'h3333);
        step(2'b01);
        set_req(0, 1, 1, 0, 'h4020, 16'h0020);
        set_req(1, 1, 1, 1, 'h4006, 16'd6);
        step(2'b10);
        set_req(1, 1, 1, 1, 'h4007, 16'd7);
        step(2'b10);
        set_req(1, 1, 1, 0, 'h4008, 16'd8);
        step(2'b10);
        set_req(1, 1, 1, 0, 'h4009, 16'd9);
        step(2'b01);
        idle();

        // Lock timeout: requester 1 waits exactly LOCK_TIMEOUT cycles.
        set_req(0, 1, 1, 1, 'h4030, 16'h0030);
        step(2'b01);
        idle();
        set_req(1, 1, 1, 0, 'h4031, 16'h0031);
        repeat (LOCK_TIMEOUT) step(2'b00);
        step(2'b10);
        idle();

        // Reset while a read is in flight: the response must never appear.
        set_req(0, 1, 0, 0, 'h7, '0);
        step(2'b01);
        idle();
        #1;
        reset = 1'b0;
        rd_exp_q.delete();
        @(negedge clk);
        check_zero("reset2");
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) begin
            step(2'b00);
            chk("rsp_dropped", 64'(rsp_valid), 0);
        end

        // Pointer restarts at requester 0 after reset.
        set_req(0, 1, 1, 0, 'h4040, 16'h0040);
        set_req(1, 1, 1, 0, 'h4041, 16'h0041);
        step(2'b01);
        step(2'b10);
        idle();
        repeat (3) step(2'b00);

        chk("wr_q_drained", 64'(wr_exp_q.size()), 0);
        chk("rd_q_drained", 64'(rd_exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
